// File: rtl/cpu_bus_ctrl_if.sv
// rtl/cpu_bus_ctrl_if.sv - CPU native bus bundle between the core and cpu_bus_ctrl
//
// Signals:
//   i_bus_req    request, held high by the CPU until o_bus_ready is seen
//   i_bus_we     1=write, 0=read
//   i_bus_addr   byte address
//   i_bus_wdata  write data, only [7:0] carries the byte
//   o_bus_rdata  read data, {24'b0, byte}
//   o_bus_ready  transfer complete
// Modports: master = CPU side, slave = controller side.
interface cpu_bus_ctrl_if;
    logic        i_bus_req;
    logic        i_bus_we;
    logic [31:0] i_bus_addr;
    logic [31:0] i_bus_wdata;
    logic [31:0] o_bus_rdata;
    logic        o_bus_ready;

    modport master (
        output i_bus_req,
        output i_bus_we,
        output i_bus_addr,
        output i_bus_wdata,
        input  o_bus_rdata,
        input  o_bus_ready
    );

    modport slave (
        input  i_bus_req,
        input  i_bus_we,
        input  i_bus_addr,
        input  i_bus_wdata,
        output o_bus_rdata,
        output o_bus_ready
    );
endinterface

// File: rtl/cpu_bus_ctrl.sv
// rtl/cpu_bus_ctrl.sv - CPU bus slave decoding to async SRAM, I/O window or unmapped space
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   bus                 CPU bus (cpu_bus_ctrl_if.slave), four-phase req/ready handshake
//   o_sram_addr         19-bit SRAM address
//   o_sram_wdata        SRAM write byte, o_sram_wdata_oe enables the data pin drivers
//   i_sram_rdata        SRAM read byte
//   o_sram_ce_n/oe_n/we_n  active-low SRAM controls
//   o_io_stb            one-cycle I/O request strobe
//   o_io_we/addr/wdata  I/O qualifiers, held for the whole I/O transfer
//   i_io_ack/i_io_rdata I/O completion with read byte in the same cycle
//   o_fault_cnt         saturating count of I/O timeouts and unmapped accesses
module cpu_bus_ctrl #(
    parameter int unsigned SRAM_WAIT     = 2,
    parameter logic [15:0] IO_PAGE       = 16'h0100,
    parameter int unsigned IO_TIMEOUT    = 255,
    parameter logic [7:0]  UNMAPPED_DATA = 8'hFF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    cpu_bus_ctrl_if.slave       bus,
    output logic [18:0]         o_sram_addr,
    output logic [7:0]          o_sram_wdata,
    output logic                o_sram_wdata_oe,
    input  logic [7:0]          i_sram_rdata,
    output logic                o_sram_ce_n,
    output logic                o_sram_oe_n,
    output logic                o_sram_we_n,
    output logic                o_io_stb,
    output logic                o_io_we,
    output logic [15:0]         o_io_addr,
    output logic [7:0]          o_io_wdata,
    input  logic                i_io_ack,
    input  logic [7:0]          i_io_rdata,
    output logic [7:0]          o_fault_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRAM_SETUP,
        S_SRAM_ACCESS,
        S_IO_REQ,
        S_IO_WAIT,
        S_UNMAP,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        R_SRAM,
        R_IO,
        R_UNMAP
    } region_t;

    // Last IO_WAIT cycle index; IO_WAIT runs for IO_TIMEOUT cycles at most.
    localparam logic [7:0] IO_LAST   = 8'(IO_TIMEOUT - 1);
    localparam logic [3:0] SRAM_LOAD = 4'(SRAM_WAIT);

    state_t      state;
    state_t      state_nxt;
    region_t     req_region;
    region_t     region_q;
    logic        we_q;
    logic [3:0]  sram_cnt;
    logic [7:0]  io_cnt;
    logic [7:0]  rdata_q;

    logic        accept;
    logic        sram_done;
    logic        io_ack_hit;
    logic        io_timeout;
    logic        release_bus;
    logic        fault_evt;

    logic        unused_wdata_hi;
    assign unused_wdata_hi = ^bus.i_bus_wdata[31:8];

    // Decode on the address presented in IDLE; it is the same value that gets latched.
    always_comb begin
        if (bus.i_bus_addr[31:19] == 13'd0) begin
            req_region = R_SRAM;
        end else if (bus.i_bus_addr[31:16] == IO_PAGE) begin
            req_region = R_IO;
        end else begin
            req_region = R_UNMAP;
        end
    end

    assign accept      = (state == S_IDLE) && bus.i_bus_req;
    assign sram_done   = (state == S_SRAM_ACCESS) && (sram_cnt == 4'd0);
    assign io_ack_hit  = (state == S_IO_WAIT) && i_io_ack;
    // An ack in the final wait cycle wins over the timeout.
    assign io_timeout  = (state == S_IO_WAIT) && !i_io_ack && (io_cnt == IO_LAST);
    assign release_bus = (state == S_RESP) && !bus.i_bus_req;
    assign fault_evt   = (state == S_UNMAP) || io_timeout;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.i_bus_req) begin
                    case (req_region)
                        R_SRAM:  state_nxt = S_SRAM_SETUP;
                        R_IO:    state_nxt = S_IO_REQ;
                        default: state_nxt = S_UNMAP;
                    endcase
                end
            end
            S_SRAM_SETUP:  state_nxt = S_SRAM_ACCESS;
            S_SRAM_ACCESS: if (sram_cnt == 4'd0) state_nxt = S_RESP;
            S_IO_REQ:      state_nxt = S_IO_WAIT;
            S_IO_WAIT:     if (i_io_ack || (io_cnt == IO_LAST)) state_nxt = S_RESP;
            S_UNMAP:       state_nxt = S_RESP;
            S_RESP:        if (!bus.i_bus_req) state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state, so an asynchronous reset releases the SRAM at once.
    always_comb begin
        o_sram_ce_n     = 1'b1;
        o_sram_oe_n     = 1'b1;
        o_sram_we_n     = 1'b1;
        o_sram_wdata_oe = 1'b0;
        o_io_stb        = 1'b0;
        bus.o_bus_ready = 1'b0;
        case (state)
            S_SRAM_SETUP: begin
                o_sram_ce_n     = 1'b0;
                o_sram_oe_n     = we_q;
                o_sram_wdata_oe = we_q;
            end
            S_SRAM_ACCESS: begin
                o_sram_ce_n     = 1'b0;
                o_sram_oe_n     = we_q;
                o_sram_we_n     = !we_q;
                o_sram_wdata_oe = we_q;
            end
            S_IO_REQ: begin
                o_io_stb = 1'b1;
            end
            S_RESP: begin
                bus.o_bus_ready = 1'b1;
                // Keep driving the SRAM data pins through RESP for write hold time.
                o_sram_wdata_oe = we_q && (region_q == R_SRAM);
            end
            default: begin
            end
        endcase
    end

    assign bus.o_bus_rdata = {24'd0, rdata_q};

    // Datapath: request latch, counters, captured read byte, fault counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            we_q         <= 1'b0;
            region_q     <= R_UNMAP;
            o_sram_addr  <= 19'd0;
            o_sram_wdata <= 8'd0;
            o_io_we      <= 1'b0;
            o_io_addr    <= 16'd0;
            o_io_wdata   <= 8'd0;
            sram_cnt     <= 4'd0;
            io_cnt       <= 8'd0;
            rdata_q      <= 8'd0;
            o_fault_cnt  <= 8'd0;
        end else begin
            if (accept) begin
                we_q     <= bus.i_bus_we;
                region_q <= req_region;
                if (req_region == R_SRAM) begin
                    o_sram_addr <= bus.i_bus_addr[18:0];
                    if (bus.i_bus_we) begin
                        o_sram_wdata <= bus.i_bus_wdata[7:0];
                    end
                end
                if (req_region == R_IO) begin
                    o_io_we    <= bus.i_bus_we;
                    o_io_addr  <= bus.i_bus_addr[15:0];
                    o_io_wdata <= bus.i_bus_wdata[7:0];
                end
            end else if (release_bus) begin
                o_io_we    <= 1'b0;
                o_io_addr  <= 16'd0;
                o_io_wdata <= 8'd0;
            end

            if (state == S_SRAM_SETUP) begin
                sram_cnt <= SRAM_LOAD;
            end else if ((state == S_SRAM_ACCESS) && (sram_cnt != 4'd0)) begin
                sram_cnt <= sram_cnt - 4'd1;
            end

            if (state == S_IO_REQ) begin
                io_cnt <= 8'd0;
            end else if (state == S_IO_WAIT) begin
                io_cnt <= io_cnt + 8'd1;
            end

            // Only reads update the returned byte; writes leave it as it was.
            if (!we_q) begin
                if (sram_done) begin
                    rdata_q <= i_sram_rdata;
                end else if (io_ack_hit) begin
                    rdata_q <= i_io_rdata;
                end else if (io_timeout || (state == S_UNMAP)) begin
                    rdata_q <= UNMAPPED_DATA;
                end
            end

            if (fault_evt && (o_fault_cnt != 8'hFF)) begin
                o_fault_cnt <= o_fault_cnt + 8'd1;
            end
        end
    end

endmodule
